// File: rtl/mul_result_sequencer.sv
// mul_result_sequencer: holds operands steady while an external combinational
// multiplier settles, captures the 64-bit product, then streams it as LO then HI
// over a valid/ready handshake with a one-cycle done pulse at the end.
module mul_result_sequencer #(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_m,
  input  logic [WIDTH-1:0]     op_q,
  output logic [WIDTH-1:0]     mul_m,
  output logic [WIDTH-1:0]     mul_q,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 busy,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_is_hi,
  input  logic                 out_ready,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, SETTLE, SEND_LO, SEND_HI} state_t;
  // settle counter reloads to WAIT_CYCLES-1 so the product is captured exactly WAIT_CYCLES edges after start
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mul_m_q, mul_m_d;
  logic [WIDTH-1:0]     mul_q_q, mul_q_d;
  logic                 done_q, done_d;
  assign mul_m = mul_m_q;
  assign mul_q = mul_q_q;
  assign done  = done_q;
  // state and datapath registers, cleared asynchronously so a reset abandons any transaction
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mul_m_q <= '0;
      mul_q_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mul_m_q <= mul_m_d;
      mul_q_q <= mul_q_d;
      done_q  <= done_d;
    end
  end
  // next state: operands load only from IDLE, so they stay frozen for the whole transaction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mul_m_d = mul_m_q;
    mul_q_d = mul_q_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        mul_m_d = op_m;
        mul_q_d = op_q;
        cnt_d   = CNT_INIT;
        state_d = SETTLE;
      end
      SETTLE: if (cnt_q == 4'd0) begin
        prod_d  = mul_result;
        state_d = SEND_LO;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      SEND_LO: state_d = out_ready ? SEND_HI : SEND_LO;
      SEND_HI: begin
        state_d = out_ready ? IDLE : SEND_HI;
        done_d  = out_ready;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs decode from state and captured product only, never from out_ready or start
  always_comb begin
    busy      = state_q != IDLE;
    out_valid = state_q == SEND_LO || state_q == SEND_HI;
    out_is_hi = state_q == SEND_HI;
    out_data  = state_q == SEND_LO ? prod_q[WIDTH-1:0] :
                state_q == SEND_HI ? prod_q[2*WIDTH-1:WIDTH] : '0;
  end
endmodule

// File: tb/tb_mul_result_sequencer.sv
// tb_mul_result_sequencer: directed vectors with a scoreboard queue checked by an independent monitor
module tb_mul_result_sequencer;
  localparam int W  = 32;
  localparam int WC = 2;
  typedef struct packed {logic hi; logic [W-1:0] data;} word_t;
  logic clock = 1'b0, clear_n = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [W-1:0] op_m = '0, op_q = '0, mul_m, mul_q, out_data;
  logic [2*W-1:0] mul_result;
  logic busy, out_valid, out_is_hi, done;
  int checks = 0, errors = 0;
  word_t sb[$];
  word_t exp_w;
  logic hi_pend = 1'b0, hold = 1'b0, hold_hi = 1'b0;
  logic [W-1:0] hold_data = '0;

  always #5 clock = ~clock;

  // behavioural stand-in for the external signed multiplier
  assign mul_result = {{W{mul_m[W-1]}}, mul_m} * {{W{mul_q[W-1]}}, mul_q};

  mul_result_sequencer #(.WIDTH(W), .WAIT_CYCLES(WC)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .op_m(op_m), .op_q(op_q),
    .mul_m(mul_m), .mul_q(mul_q), .mul_result(mul_result), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_is_hi(out_is_hi),
    .out_ready(out_ready), .done(done)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // monitor: pops the scoreboard on each transfer, checks hold under backpressure and the done pulse
  always @(negedge clock) begin
    if (!clear_n) begin
      hi_pend = 1'b0;
      hold    = 1'b0;
    end else begin
      chk("done pulse", done, hi_pend);
      if (hold) begin
        chk("hold valid", out_valid, 1);
        chk("hold data", out_data, hold_data);
        chk("hold is_hi", out_is_hi, hold_hi);
      end
      if (!out_valid) chk("idle data zero", out_data, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected word: got %0h is_hi %0b expected none", out_data, out_is_hi);
        end else begin
          exp_w = sb.pop_front();
          chk("word data", out_data, exp_w.data);
          chk("word is_hi", out_is_hi, exp_w.hi);
        end
      end
      hi_pend   = out_valid && out_ready && out_is_hi;
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_hi   = out_is_hi;
    end
  end

  task automatic run(input logic [W-1:0] m, q, lo, hi, input int ls, hs, input bit intr);
    int cyc = 0, lc = 0, hc = 0;
    bit seen_hi = 1'b0;
    op_m = m; op_q = q; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back({1'b0, lo});
    sb.push_back({1'b1, hi});
    chk("busy after start", busy, 1);
    chk("mul_m load", mul_m, m);
    chk("mul_q load", mul_q, q);
    if (intr) begin
      op_m = ~m; op_q = q + 1; start = 1'b1;
      tick();
      start = 1'b0; cyc = 1;
      chk("mul_m ignores busy start", mul_m, m);
      chk("mul_q ignores busy start", mul_q, q);
    end
    while (!done && cyc < 64) begin
      if (out_valid && !out_is_hi) begin
        out_ready = lc >= ls;
        if (lc < ls) lc++;
      end else if (out_valid) begin
        out_ready = hc >= hs;
        if (hc < hs) hc++;
        if (!seen_hi) begin
          seen_hi = 1'b1;
          chk("mul_m stable", mul_m, m);
          chk("mul_q stable", mul_q, q);
        end
      end else out_ready = 1'b1;
      tick();
      cyc++;
    end
    chk("done seen", done, 1);
    chk("done latency", cyc, WC + 2 + ls + hs);
    chk("busy after done", busy, 0);
  endtask

  task automatic abort(input logic [W-1:0] m, q, input bit in_hi);
    int n = 0;
    op_m = m; op_q = q; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back({1'b0, m * q});
    sb.push_back({1'b1, W'(0)});
    if (in_hi) begin
      while (!(out_valid && out_is_hi) && n < 20) begin tick(); n++; end
      out_ready = 1'b0;
      chk("reached SEND_HI", out_valid && out_is_hi, 1);
      tick();
    end else chk("in SETTLE", busy && !out_valid, 1);
    #2 clear_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_is_hi", out_is_hi, 0);
    chk("rst done", done, 0);
    chk("rst out_data", out_data, 0);
    chk("rst mul_m", mul_m, 0);
    chk("rst mul_q", mul_q, 0);
    sb.delete();
    out_ready = 1'b1;
    tick();
    #2 clear_n = 1'b1;
    for (int i = 0; i < WC + 4; i++) begin
      tick();
      chk("no emit after reset", out_valid, 0);
      chk("no done after reset", done, 0);
    end
  endtask

  initial begin
    #2 clear_n = 1'b0;
    #2;
    chk("init busy", busy, 0);
    chk("init out_valid", out_valid, 0);
    chk("init out_is_hi", out_is_hi, 0);
    chk("init done", done, 0);
    chk("init out_data", out_data, 0);
    chk("init mul_m", mul_m, 0);
    chk("init mul_q", mul_q, 0);
    #8 clear_n = 1'b1;
    tick();
    tick();
    run(32'd3, 32'd4, 32'h0000000C, 32'h00000000, 0, 0, 1'b0);
    run(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
    run(32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 0, 0, 1'b0);
    run(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h00000000, 4, 3, 1'b0);
    run(32'd6, 32'd7, 32'h0000002A, 32'h00000000, 0, 0, 1'b1);
    abort(32'd9, 32'd9, 1'b0);
    abort(32'd9, 32'd9, 1'b1);
    run(32'd5, 32'hFFFFFFFD, 32'hFFFFFFF1, 32'hFFFFFFFF, 0, 0, 1'b0);
    repeat (3) tick();
    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end
endmodule
